// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM stage of the RV32I pipeline:
//   - pipeline status codes handed down from EX_MEM
//   - load/store op codes
//   - MEM stage FSM state encoding
//   - xfer_size(): number of bytes moved for a given load/store op
// ---------------------------------------------------------------------------
package mem_stage_pkg;

   // Status codes from EX_MEM
   localparam logic [2:0] ST_NOP    = 3'b000;
   localparam logic [2:0] ST_REG    = 3'b001;
   localparam logic [2:0] ST_STORE  = 3'b010;
   localparam logic [2:0] ST_LOAD   = 3'b011;
   localparam logic [2:0] ST_BRANCH = 3'b100;
   localparam logic [2:0] ST_JAL    = 3'b101;

   // Load/store op codes
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_XFER = 2'd1,
      MEM_WAIT = 2'd2,
      MEM_DONE = 2'd3
   } mem_state_t;

   // Bytes moved by a load/store op; anything unrecognised is a word.
   function automatic logic [2:0] xfer_size(input logic [5:0] op);
      logic [2:0] n;
      case (op)
         OP_LB, OP_LBU, OP_SB: n = 3'd1;
         OP_LH, OP_LHU, OP_SH: n = 3'd2;
         default:              n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// ---------------------------------------------------------------------------
// mem_stage_load_ext
// Combinational size/sign extension of the assembled load buffer.
// Only the low N bytes of i_lbuf are used (N from the op).
// Ports:
//   i_op    in   6       load op (LB/LH/LW/LBU/LHU)
//   i_lbuf  in   DATA_W  little-endian bytes collected from the bus
//   o_data  out  DATA_W  extended writeback value
// ---------------------------------------------------------------------------
module mem_stage_load_ext
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [5:0]        i_op,
   input  logic [DATA_W-1:0] i_lbuf,
   output logic [DATA_W-1:0] o_data
);

   // Select extension by op
   always_comb begin
      o_data = {DATA_W{1'b0}};
      case (i_op)
         OP_LB:   o_data = {{(DATA_W-8){i_lbuf[7]}}, i_lbuf[7:0]};
         OP_LBU:  o_data = {{(DATA_W-8){1'b0}}, i_lbuf[7:0]};
         OP_LH:   o_data = {{(DATA_W-16){i_lbuf[15]}}, i_lbuf[15:0]};
         OP_LHU:  o_data = {{(DATA_W-16){1'b0}}, i_lbuf[15:0]};
         default: o_data = i_lbuf;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM stage of the 5-stage RV32I pipeline (between EX_MEM and MEM_WB).
// Non-memory ops pass straight through to writeback. Loads and stores are
// run byte-serially over the shared 8-bit RAM bus while stall_req_out holds
// the pipeline.
//
// Optional feature: define MEM_FORWARD_EN to add the fwd_* ports used for
// ID-stage forwarding (combinational copies of the writeback outputs).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   op_in             load/store op from EX_MEM
//   status_in         000 nop, 001 reg, 010 store, 011 load, 100 branch, 101 jal
//   mem_address_in    load/store byte address
//   target_data_in    ALU/link result or store data
//   reg_address_in    destination register
//   wd_out/wreg_out/wdata_out   writeback to MEM_WB
//   stall_req_out     pipeline hold request
//   mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out   byte bus master
//   mem_gnt_in        arbiter grant (a byte moves only in a granted cycle)
//   mem_rdata_in      read byte, valid the cycle after its granted read
//   fwd_wd_out/fwd_reg_out/fwd_data_out   (MEM_FORWARD_EN only)
// ---------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        op_in,
   input  logic [2:0]        status_in,
   input  logic [ADDR_W-1:0] mem_address_in,
   input  logic [DATA_W-1:0] target_data_in,
   input  logic [4:0]        reg_address_in,
   output logic              wd_out,
   output logic [4:0]        wreg_out,
   output logic [DATA_W-1:0] wdata_out,
   output logic              stall_req_out,
   output logic              mem_req_out,
   output logic              mem_we_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [7:0]        mem_wdata_out,
   input  logic              mem_gnt_in,
   input  logic [7:0]        mem_rdata_in
`ifdef MEM_FORWARD_EN
   ,
   output logic              fwd_wd_out,
   output logic [4:0]        fwd_reg_out,
   output logic [DATA_W-1:0] fwd_data_out
`endif
);

   mem_state_t        r_state;
   logic [2:0]        r_cnt;
   logic [DATA_W-1:0] r_lbuf;
   logic              r_rd_pend;
   logic [1:0]        r_rd_idx;

   logic [2:0]        w_size;
   logic              w_is_load;
   logic              w_is_store;
   logic              w_is_mem;
   logic [2:0]        w_cur_idx;
   logic              w_last;
   logic [DATA_W-1:0] w_ext;

   assign w_size     = xfer_size(op_in);
   assign w_is_load  = (status_in == ST_LOAD);
   assign w_is_store = (status_in == ST_STORE);
   assign w_is_mem   = w_is_load | w_is_store;

   // Byte on the bus this cycle: byte 0 while detecting in IDLE, else cnt.
   assign w_cur_idx  = (r_state == MEM_XFER) ? r_cnt : 3'd0;
   // The byte on the bus is the final one of the access.
   assign w_last     = ((w_cur_idx + 3'd1) == w_size);

   mem_stage_load_ext #(
      .DATA_W (DATA_W)
   ) u_load_ext (
      .i_op   (op_in),
      .i_lbuf (r_lbuf),
      .o_data (w_ext)
   );

   // Access FSM, byte counter and read-capture pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= MEM_IDLE;
         r_cnt     <= 3'd0;
         r_lbuf    <= {DATA_W{1'b0}};
         r_rd_pend <= 1'b0;
         r_rd_idx  <= 2'd0;
      end else begin
         // Read data arrives one cycle after its grant, independent of the
         // grant in the arrival cycle.
         r_rd_pend <= 1'b0;
         if (r_rd_pend) begin
            case (r_rd_idx)
               2'd0:    r_lbuf[7:0]   <= mem_rdata_in;
               2'd1:    r_lbuf[15:8]  <= mem_rdata_in;
               2'd2:    r_lbuf[23:16] <= mem_rdata_in;
               default: r_lbuf[31:24] <= mem_rdata_in;
            endcase
         end

         case (r_state)
            MEM_IDLE: begin
               if (w_is_mem) begin
                  if (mem_gnt_in) begin
                     r_rd_pend <= w_is_load;
                     r_rd_idx  <= 2'd0;
                     r_cnt     <= 3'd1;
                     if (w_last) begin
                        r_state <= w_is_load ? MEM_WAIT : MEM_DONE;
                     end else begin
                        r_state <= MEM_XFER;
                     end
                  end else begin
                     r_cnt   <= 3'd0;
                     r_state <= MEM_XFER;
                  end
               end else begin
                  r_cnt   <= 3'd0;
                  r_state <= MEM_IDLE;
               end
            end
            MEM_XFER: begin
               // Without a grant everything holds, keeping address/data stable.
               if (mem_gnt_in) begin
                  r_rd_pend <= w_is_load;
                  r_rd_idx  <= r_cnt[1:0];
                  r_cnt     <= r_cnt + 3'd1;
                  if (w_last) begin
                     r_state <= w_is_load ? MEM_WAIT : MEM_DONE;
                  end else begin
                     r_state <= MEM_XFER;
                  end
               end else begin
                  r_state <= MEM_XFER;
               end
            end
            MEM_WAIT: begin
               r_state <= MEM_DONE;
            end
            MEM_DONE: begin
               r_cnt   <= 3'd0;
               r_state <= MEM_IDLE;
            end
            default: begin
               r_cnt   <= 3'd0;
               r_state <= MEM_IDLE;
            end
         endcase
      end
   end

   // Output decode; everything is forced low while reset is asserted
   always_comb begin
      wd_out        = 1'b0;
      wreg_out      = 5'd0;
      wdata_out     = {DATA_W{1'b0}};
      stall_req_out = 1'b0;
      mem_req_out   = 1'b0;
      mem_we_out    = 1'b0;
      mem_addr_out  = {ADDR_W{1'b0}};
      mem_wdata_out = 8'd0;
      if (rst) begin
         wd_out = 1'b0;
      end else begin
         case (r_state)
            MEM_IDLE, MEM_XFER: begin
               if (w_is_mem) begin
                  stall_req_out = 1'b1;
                  mem_req_out   = 1'b1;
                  mem_we_out    = w_is_store;
                  mem_addr_out  = mem_address_in + {{(ADDR_W-3){1'b0}}, w_cur_idx};
                  if (w_is_store) begin
                     case (w_cur_idx[1:0])
                        2'd0:    mem_wdata_out = target_data_in[7:0];
                        2'd1:    mem_wdata_out = target_data_in[15:8];
                        2'd2:    mem_wdata_out = target_data_in[23:16];
                        default: mem_wdata_out = target_data_in[31:24];
                     endcase
                  end else begin
                     mem_wdata_out = 8'd0;
                  end
               end else if ((r_state == MEM_IDLE) &&
                            ((status_in == ST_REG) || (status_in == ST_JAL))) begin
                  wd_out    = 1'b1;
                  wreg_out  = reg_address_in;
                  wdata_out = target_data_in;
               end else begin
                  wd_out = 1'b0;
               end
            end
            MEM_WAIT: begin
               stall_req_out = 1'b1;
            end
            MEM_DONE: begin
               if (w_is_load) begin
                  wd_out    = 1'b1;
                  wreg_out  = reg_address_in;
                  wdata_out = w_ext;
               end else begin
                  wd_out = 1'b0;
               end
            end
            default: begin
               wd_out = 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_FORWARD_EN
   assign fwd_wd_out   = wd_out;
   assign fwd_reg_out  = wreg_out;
   assign fwd_data_out = wdata_out;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage with a byte-RAM bus model.
// ---------------------------------------------------------------------------
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk;
   logic        rst;
   logic [5:0]  op_in;
   logic [2:0]  status_in;
   logic [31:0] mem_address_in;
   logic [31:0] target_data_in;
   logic [4:0]  reg_address_in;
   logic        wd_out;
   logic [4:0]  wreg_out;
   logic [31:0] wdata_out;
   logic        stall_req_out;
   logic        mem_req_out;
   logic        mem_we_out;
   logic [31:0] mem_addr_out;
   logic [7:0]  mem_wdata_out;
   logic        mem_gnt_in;
   logic [7:0]  mem_rdata_in;

   int errors;
   int checks;

   logic [7:0]  mem [0:2047];
   logic [31:0] alog [$];
   logic        mm_rd_fire;
   logic [10:0] mm_rd_idx;
   logic [31:0] hold_addr;
   logic [7:0]  hold_data;

   mem_stage dut (
      .clk            (clk),
      .rst            (rst),
      .op_in          (op_in),
      .status_in      (status_in),
      .mem_address_in (mem_address_in),
      .target_data_in (target_data_in),
      .reg_address_in (reg_address_in),
      .wd_out         (wd_out),
      .wreg_out       (wreg_out),
      .wdata_out      (wdata_out),
      .stall_req_out  (stall_req_out),
      .mem_req_out    (mem_req_out),
      .mem_we_out     (mem_we_out),
      .mem_addr_out   (mem_addr_out),
      .mem_wdata_out  (mem_wdata_out),
      .mem_gnt_in     (mem_gnt_in),
      .mem_rdata_in   (mem_rdata_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte RAM: granted writes land at the edge, granted reads return data
   // just after the edge so it is valid for the whole following cycle.
   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      mem[11'h100] = 8'h78; mem[11'h101] = 8'h56;
      mem[11'h102] = 8'h34; mem[11'h103] = 8'h12;
      mem[11'h200] = 8'h80; mem[11'h201] = 8'h9A;
      mem[11'h303] = 8'h5A;
      mem[11'h400] = 8'h11; mem[11'h401] = 8'h22;
      mem[11'h402] = 8'h33; mem[11'h403] = 8'h44;
      mem[11'h502] = 8'h77;
      mem_rdata_in = 8'hEE;
      forever begin
         @(posedge clk);
         mm_rd_fire = 1'b0;
         if (!rst && mem_req_out && mem_gnt_in) begin
            alog.push_back(mem_addr_out);
            if (mem_we_out) begin
               mem[mem_addr_out[10:0]] = mem_wdata_out;
            end else begin
               mm_rd_fire = 1'b1;
               mm_rd_idx  = mem_addr_out[10:0];
            end
         end
         #1;
         mem_rdata_in = mm_rd_fire ? mem[mm_rd_idx] : 8'hEE;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Run one load/store; gpat bit i is the grant in access cycle i.
   task automatic do_access(input string tag, input logic [5:0] op, input logic [2:0] st,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [63:0] gpat, input int exp_stall,
                            input logic exp_wd, input logic [31:0] exp_wdata,
                            output int base);
      int cyc;
      base = alog.size();
      @(negedge clk);
      op_in          = op;
      status_in      = st;
      mem_address_in = addr;
      target_data_in = data;
      reg_address_in = 5'd9;
      cyc            = 0;
      mem_gnt_in     = gpat[0];
      #1;
      while (stall_req_out === 1'b1 && cyc < 40) begin
         if (cyc == 2) begin
            hold_addr = mem_addr_out;
            hold_data = mem_wdata_out;
         end
         @(negedge clk);
         cyc++;
         mem_gnt_in = gpat[cyc];
         #1;
      end
      check_val({tag, "_stall_cycles"}, cyc, exp_stall);
      check_val({tag, "_done_req"}, {31'd0, mem_req_out}, 32'd0);
      check_val({tag, "_done_wd"}, {31'd0, wd_out}, {31'd0, exp_wd});
      if (exp_wd) begin
         check_val({tag, "_done_wdata"}, wdata_out, exp_wdata);
         check_val({tag, "_done_wreg"}, {27'd0, wreg_out}, 32'd9);
      end
      @(negedge clk);
      status_in  = ST_NOP;
      mem_gnt_in = 1'b0;
   endtask

   initial begin
      int base;
      errors = 0;
      checks = 0;
      rst            = 1'b1;
      op_in          = 6'd0;
      status_in      = ST_REG;
      mem_address_in = 32'd0;
      target_data_in = 32'h0000_1234;
      reg_address_in = 5'd5;
      mem_gnt_in     = 1'b0;
      #1;
      // Reset: combinational outputs gated low even for a reg op
      check_val("rst_wd", {31'd0, wd_out}, 32'd0);
      check_val("rst_wdata", wdata_out, 32'd0);
      check_val("rst_stall", {31'd0, stall_req_out}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      // ALU op passthrough
      check_val("alu_wd", {31'd0, wd_out}, 32'd1);
      check_val("alu_wreg", {27'd0, wreg_out}, 32'd5);
      check_val("alu_wdata", wdata_out, 32'h0000_1234);
      check_val("alu_stall", {31'd0, stall_req_out}, 32'd0);
      @(negedge clk);
      status_in = ST_BRANCH;
      #1;
      check_val("br_wd", {31'd0, wd_out}, 32'd0);
      check_val("br_wdata", wdata_out, 32'd0);
      status_in = ST_NOP;

      // LW, continuous grant
      do_access("lw", OP_LW, ST_LOAD, 32'h100, 32'd0, {64{1'b1}}, 5, 1'b1, 32'h1234_5678, base);
      check_val("lw_nbytes", alog.size() - base, 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < alog.size())
            check_val("lw_addr", alog[base+i], 32'h100 + i);
      end

      do_access("lb", OP_LB, ST_LOAD, 32'h200, 32'd0, {64{1'b1}}, 2, 1'b1, 32'hFFFF_FF80, base);
      do_access("lbu", OP_LBU, ST_LOAD, 32'h200, 32'd0, {64{1'b1}}, 2, 1'b1, 32'h0000_0080, base);
      do_access("lh", OP_LH, ST_LOAD, 32'h200, 32'd0, {64{1'b1}}, 3, 1'b1, 32'hFFFF_9A80, base);
      do_access("lhu", OP_LHU, ST_LOAD, 32'h102, 32'd0, {64{1'b1}}, 3, 1'b1, 32'h0000_1234, base);

      // SH unaligned with grant gap on the second byte
      do_access("sh", OP_SH, ST_STORE, 32'h301, 32'hAABB_CCDD, 64'hFFFF_FFFF_FFFF_FFF1,
                5, 1'b0, 32'd0, base);
      check_val("sh_hold_addr", hold_addr, 32'h302);
      check_val("sh_hold_data", {24'd0, hold_data}, 32'h0000_00CC);
      check_val("sh_m301", {24'd0, mem[11'h301]}, 32'h0000_00DD);
      check_val("sh_m302", {24'd0, mem[11'h302]}, 32'h0000_00CC);
      check_val("sh_m303", {24'd0, mem[11'h303]}, 32'h0000_005A);

      do_access("sw", OP_SW, ST_STORE, 32'h600, 32'hDEAD_BEEF, {64{1'b1}}, 4, 1'b0, 32'd0, base);
      check_val("sw_mem", {mem[11'h603], mem[11'h602], mem[11'h601], mem[11'h600]}, 32'hDEAD_BEEF);

      do_access("sb", OP_SB, ST_STORE, 32'h700, 32'h1234_5678, {64{1'b1}}, 1, 1'b0, 32'd0, base);
      check_val("sb_mem", {24'd0, mem[11'h700]}, 32'h0000_0078);
      check_val("sb_m701", {24'd0, mem[11'h701]}, 32'h0000_0000);

      // LW with grant dropping after byte 1
      do_access("lw_gap", OP_LW, ST_LOAD, 32'h400, 32'd0, 64'hFFFF_FFFF_FFFF_FFF3,
                7, 1'b1, 32'h4433_2211, base);

      // Reset in the middle of an SW
      @(negedge clk);
      op_in          = OP_SW;
      status_in      = ST_STORE;
      mem_address_in = 32'h500;
      target_data_in = 32'h1122_3344;
      mem_gnt_in     = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("rstx_req", {31'd0, mem_req_out}, 32'd0);
      check_val("rstx_stall", {31'd0, stall_req_out}, 32'd0);
      check_val("rstx_addr", mem_addr_out, 32'd0);
      check_val("rstx_m500", {24'd0, mem[11'h500]}, 32'h0000_0044);
      check_val("rstx_m501", {24'd0, mem[11'h501]}, 32'h0000_0033);
      check_val("rstx_m502", {24'd0, mem[11'h502]}, 32'h0000_0077);
      @(negedge clk);
      rst        = 1'b0;
      status_in  = ST_NOP;
      mem_gnt_in = 1'b0;
      #1;
      check_val("post_req", {31'd0, mem_req_out}, 32'd0);
      check_val("post_wd", {31'd0, wd_out}, 32'd0);
      check_val("post_addr", mem_addr_out, 32'd0);
      @(negedge clk);
      status_in      = ST_JAL;
      reg_address_in = 5'd3;
      target_data_in = 32'h0000_CAFE;
      #1;
      check_val("idle_wd", {31'd0, wd_out}, 32'd1);
      check_val("idle_wdata", wdata_out, 32'h0000_CAFE);
      check_val("idle_stall", {31'd0, stall_req_out}, 32'd0);
      @(negedge clk);
      status_in = ST_NOP;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
